// File: rtl/ysyx_23060061_pkg.sv
// Shared definitions for the instruction SRAM responder.
//   state_e          : responder FSM encoding (IDLE / WAIT / RESP)
//   DEFAULT_*        : default geometry, base address and read latency
//   ERR_RESP_DATA    : data word returned alongside resp_err
//   addr_ok()        : word-aligned and inside [base, base+span)
package ysyx_23060061_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h8000_0000;
  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam logic [31:0] ERR_RESP_DATA       = 32'h0;

  // The subtraction is done in 33 bits so that an address below base shows
  // up as a borrow instead of wrapping into a large in-range offset.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && !off[32] && (off < span);
  endfunction

endpackage

// File: rtl/ysyx_23060061_sram_array.sv
// Word storage for the instruction SRAM.
//   clk     : clock
//   rd_en   : capture mem[rd_idx] into rd_data at the rising edge
//   rd_idx  : read word index
//   rd_data : registered read word, holds until the next rd_en
//   wr_en   : write mem[wr_idx] <= wr_data at the rising edge
//   wr_idx  : write word index
//   wr_data : write word
// No reset: contents survive a block reset. A read and write of the same
// word on the same edge returns the old word (read-before-write).
module ysyx_23060061_sram_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ysyx_23060061_inst_sram.sv
// Instruction-fetch SRAM responder with a fixed, parameterised latency.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : fetch request handshake, req_addr = byte pc
//   resp_valid/resp_ready  : response handshake, resp_data/resp_err payload
//   wr_en/wr_addr/wr_data  : loader write port, usable in any state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; payload is held stable while valid=1 and ready=0. Only one request
// is outstanding: req_ready is 1 only in IDLE and never in the cycle of a
// response handshake.
module ysyx_23060061_inst_sram
  import ysyx_23060061_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LOAD_CNT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_data;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      lookup_addr;
  logic             lookup_ok;

  // With LATENCY=1 the array is read on the accept edge itself, so the
  // address comes straight from the request port rather than addr_q.
  assign lookup_addr = (state_q == IDLE) ? req_addr : addr_q;
  assign lookup_ok   = addr_ok(lookup_addr, BASE_ADDR, SPAN);
  // Truncation to the index width is safe only because the range check
  // already rejected anything outside the array.
  assign rd_idx      = IDX_W'((lookup_addr - BASE_ADDR) >> 2);

  assign wr_ok  = wr_en && !rst && addr_ok(wr_addr, BASE_ADDR, SPAN);
  assign wr_idx = IDX_W'((wr_addr - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            rd_en   = lookup_ok;
            err_d   = !lookup_ok;
          end else begin
            state_d = WAIT;
            cnt_d   = LOAD_CNT;
          end
        end
      end
      WAIT: begin
        // Leave on the edge where the decremented count reaches 0, which
        // puts the first RESP cycle exactly LATENCY cycles after accept.
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = RESP;
          rd_en   = lookup_ok;
          err_d   = !lookup_ok;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  ysyx_23060061_sram_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_ok),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  // Payload is forced to zero outside a valid response; the reset term keeps
  // a transaction dropped by reset from ever showing a response cycle.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q) ? rd_data : ERR_RESP_DATA;

endmodule

// File: tb/tb_ysyx_23060061_inst_sram.sv
module tb_ysyx_23060061_inst_sram;

  localparam int          N     = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 15;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic [31:0] req_addr   [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_data  [N];
  logic        resp_err   [N];
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Four responders share the loader port, so their contents stay identical.
  for (genvar g = 0; g < N; g++) begin : g_dut
    ysyx_23060061_inst_sram #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 15)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_data  (resp_data[g]),
      .resp_err   (resp_err[g]),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int unsigned];

  function automatic logic in_range(input logic [31:0] addr);
    logic [63:0] a;
    logic [63:0] lo;
    logic [63:0] hi;
    a  = {32'h0, addr};
    lo = {32'h0, BASE};
    hi = lo + 64'(4 * DEPTH);
    return (addr[1:0] == 2'b00) && (a >= lo) && (a < hi);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] addr);
    return int'((addr - BASE) / 4);
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic e);
    e = !in_range(addr);
    d = e ? 32'h0 : ref_mem[word_of(addr)];
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  bit   front_seen = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (resp_valid[i]) begin
        if (exp_q.size() == 0 || exp_q[0].inst != i) begin
          checks++;
          fails++;
          $display("FAIL spurious_resp inst %0d @cycle %0d: got resp_valid=1, expected no response", i, cyc);
        end else begin
          check("resp_data", resp_data[i], exp_q[0].data);
          check("resp_err", 32'(resp_err[i]), 32'(exp_q[0].err));
          if (!front_seen) begin
            check("resp_latency", cyc, exp_q[0].due);
            front_seen = 1'b1;
          end
          if (resp_ready[i]) begin
            void'(exp_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end else begin
        check("idle_data_zero", resp_data[i], 32'h0);
        check("idle_err_zero", 32'(resp_err[i]), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (in_range(addr)) ref_mem[word_of(addr)] = data;
  endtask

  task automatic push_exp(input int i, input logic [31:0] addr);
    exp_t t;
    t.inst = i;
    model_read(addr, t.data, t.err);
    t.due  = cyc + lat_of(i);
    exp_q.push_back(t);
  endtask

  // hold = number of RESP cycles with resp_ready=0 before the handshake.
  task automatic do_read(input int i, input logic [31:0] addr, input int hold);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_addr[i] = addr; resp_ready[i] = (hold == 0);
    @(negedge clk);
    check("accept_ready", 32'(req_ready[i]), 32'h1);
    push_exp(i, addr);
    @(posedge clk); #1;
    req_valid[i] = (hold > 0);
    req_addr[i]  = $urandom;
    @(negedge clk);
    n = 0;
    while (!resp_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid[i]) begin
      checks++;
      fails++;
      $display("FAIL resp_timeout inst %0d: got no resp_valid in 40 cycles, expected one", i);
      exp_q.delete();
      front_seen    = 1'b0;
      req_valid[i]  = 1'b0;
      resp_ready[i] = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("busy_not_ready", 32'(req_ready[i]), 32'h0);
      @(posedge clk); #1;
      req_addr[i] = $urandom;
      if (h == hold - 1) begin
        resp_ready[i] = 1'b1;
        req_valid[i]  = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready[i] = 1'b0;
    req_valid[i]  = 1'b0;
    @(negedge clk);
    check("ready_after_resp", 32'(req_ready[i]), 32'h1);
    check("resp_consumed", exp_q.size(), 32'h0);
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) check("ready_in_reset", 32'(req_ready[i]), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("post_reset_ready", 32'(req_ready[i]), 32'h1);
      check("post_reset_valid", 32'(resp_valid[i]), 32'h0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] w7;
    wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = 32'h0; resp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    reset_all();

    // Load test
    write_word(BASE, 32'h0000_0513);
    reset_all();
    do_read(1, BASE, 0);

    // Preload plus boundary words
    for (int w = 0; w < 128; w++) write_word(BASE + 32'(4 * w), $urandom);
    write_word(BASE + 32'(4 * (DEPTH - 1)), $urandom);
    do_read(1, BASE + 32'(4 * (DEPTH - 1)), 0);

    // Dropped writes: misaligned, past the end, below base
    write_word(BASE + 32'd42, 32'hDEAD_BEEF);
    write_word(BASE + 32'(4 * DEPTH), 32'hDEAD_BEEF);
    write_word(BASE - 32'd4, 32'hDEAD_BEEF);
    do_read(1, BASE + 32'd40, 0);
    do_read(1, BASE + 32'd44, 0);

    // Error responses
    do_read(1, 32'h8000_0002, 0);
    do_read(1, 32'h7FFF_FFFC, 0);
    do_read(1, 32'h8000_4000, 0);
    do_read(0, 32'hFFFF_FFFC, 0);
    do_read(3, 32'h0000_0000, 0);

    // Backpressure, data and error
    do_read(1, BASE + 32'd12, 5);
    do_read(2, BASE + 32'd1, 3);

    // Collision on the RESP-entry edge (LATENCY=2)
    write_word(BASE, 32'hAAAA_AAAA);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = BASE; resp_ready[1] = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(req_ready[1]), 32'h1);
    push_exp(1, BASE);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wr_en = 1'b1; wr_addr = BASE; wr_data = 32'h5555_5555;
    @(posedge clk); #1;
    wr_en = 1'b0;
    ref_mem[0] = 32'h5555_5555;
    @(posedge clk); #1;
    resp_ready[1] = 1'b0;
    @(negedge clk);
    check("collision_consumed", exp_q.size(), 32'h0);
    do_read(1, BASE, 0);

    // Reset mid-WAIT (LATENCY=3): request must vanish
    @(posedge clk); #1;
    req_valid[2] = 1'b1; req_addr[2] = BASE + 32'd16; resp_ready[2] = 1'b1;
    @(negedge clk);
    check("accept_ready", 32'(req_ready[2]), 32'h1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0; rst[2] = 1'b1;
    @(negedge clk);
    check("ready_in_reset", 32'(req_ready[2]), 32'h0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready[2]), 32'h1);
    repeat (20) @(negedge clk);
    resp_ready[2] = 1'b0;
    do_read(2, BASE + 32'd16, 0);

    // Reset mid-RESP (LATENCY=2, response being held off)
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd20; resp_ready[1] = 1'b0;
    @(negedge clk);
    check("accept_ready", 32'(req_ready[1]), 32'h1);
    push_exp(1, BASE + 32'd20);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    exp_q.delete();
    front_seen = 1'b0;
    repeat (20) @(negedge clk);
    check("ready_after_resp_reset", 32'(req_ready[1]), 32'h1);

    // Writes while in reset are ignored; contents survive reset
    w7 = ref_mem[7];
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    wr_en = 1'b1; wr_addr = BASE + 32'd28; wr_data = ~w7;
    @(posedge clk); #1;
    wr_en = 1'b0;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    do_read(3, BASE + 32'd28, 0);
    check("reset_write_model", ref_mem[7], w7);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0:       a = BASE + 32'($urandom_range(0, 127) * 4) + 32'($urandom_range(1, 3));
        1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
        2:       a = BASE - 32'($urandom_range(1, 255) * 4);
        default: a = BASE + 32'($urandom_range(0, 127) * 4);
      endcase
      do_read($urandom_range(0, N - 1), a, $urandom_range(0, 3));
    end

    // Latency sweep: 100 sequential pcs at LATENCY=1 and LATENCY=15
    for (int w = 0; w < 100; w++) do_read(0, BASE + 32'(4 * w), 0);
    for (int w = 0; w < 100; w++) do_read(3, BASE + 32'(4 * w), 0);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_23060061_inst_sram.md
YSYX_23060061_INST_SRAM -- requirements
Module: ysyx_23060061_inst_sram

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096: storage depth in 32-bit words, a power of two.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2: cycles from request acceptance to first resp_valid; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1: the fetch initiator presents an address.
REQ-007 The block SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-008 The block SHALL have port req_addr, input, 32: fetch byte address (pc).
REQ-009 The block SHALL have port resp_valid, output, 1: resp_data/resp_err are valid.
REQ-010 The block SHALL have port resp_ready, input, 1: the initiator consumes the response.
REQ-011 The block SHALL have port resp_data, output, 32: the instruction word.
REQ-012 The block SHALL have port resp_err, output, 1: the access was misaligned or out of range.
REQ-013 The block SHALL have port wr_en, input, 1: loader write strobe.
REQ-014 The block SHALL have port wr_addr, input, 32: loader byte address, word-aligned.
REQ-015 The block SHALL have port wr_data, input, 32: loader write word.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP, and SHALL hold at most one outstanding request.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, a cycle with req_valid=1 SHALL be the accept cycle: the block captures req_addr, loads the latency counter with LATENCY-1, and moves to WAIT; if LATENCY=1 it moves directly to RESP.
REQ-019 In WAIT, the block SHALL decrement the counter each cycle and enter RESP on the edge where the counter equals 0.
REQ-020 resp_valid SHALL first be high in cycle k+LATENCY, where cycle k is the accept cycle.
REQ-021 On the edge entering RESP, the block SHALL read the array and register resp_data and resp_err.
REQ-022 In RESP, resp_valid SHALL be 1, and resp_data and resp_err SHALL stay stable until the cycle in which resp_ready=1.
REQ-023 On the RESP handshake, the block SHALL return to IDLE, with no back-to-back acceptance in the same cycle.
REQ-024 Accepted-address error: the response SHALL be resp_err=1 with resp_data=0 when addr[1:0]!=0, when addr<BASE_ADDR, or when addr>=BASE_ADDR+4*DEPTH_WORDS.
REQ-025 Word index SHALL be computed as (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits only after the range check.
REQ-026 A wr_en write SHALL commit at the rising edge, in any state.
REQ-027 A write with an out-of-range address or wr_addr[1:0]!=0 SHALL be silently dropped.
REQ-028 A write and a read of the same word on the same edge SHALL return the old word (read-before-write).
REQ-029 req_addr and req_valid changes outside IDLE SHALL be ignored.
REQ-030 resp_valid SHALL never be asserted without a preceding accept.
REQ-031 resp_data and resp_err SHALL be 0 whenever resp_valid=0.

Reset
REQ-032 When rst=1 at an edge, the block SHALL go to IDLE, clear the counter, and drive req_ready=0 during the reset cycle; after reset, req_ready=1, resp_valid=0, resp_data=0 and resp_err=0.
REQ-033 Reset mid-WAIT or mid-RESP SHALL drop the transaction, and no response SHALL ever appear for it.
REQ-034 Reset SHALL NOT clear array contents, and writes while rst=1 SHALL be ignored.

Structure
REQ-035 A shared package ysyx_23060061_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), the default BASE_ADDR, DEPTH_WORDS and LATENCY constants, and the error-response data constant (32'h0).
REQ-036 Storage SHALL be a sub-module ysyx_23060061_sram_array: 1 synchronous-read port and 1 synchronous-write port, read-before-write, with no reset.
REQ-037 The top level SHALL contain only the FSM, the counter, the range check and the output registers.

Verification
REQ-038 Load test: write 32'h0000_0513 to 32'h8000_0000, reset, accept a read at 32'h8000_0000 in cycle k with resp_ready=1 -> resp_valid=1 in cycle k+2 only, resp_data=32'h0000_0513, resp_err=0, req_ready=1 in cycle k+3.
REQ-039 Backpressure test: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data are stable throughout, req_ready=0; a new req_addr presented meanwhile is not accepted.
REQ-040 Error test: read 32'h8000_0002 -> resp_err=1, resp_data=0; read 32'h7FFF_FFFC -> resp_err=1; read 32'h8000_4000 (DEPTH_WORDS=4096) -> resp_err=1.
REQ-041 Collision test: with word 0=32'hAAAA_AAAA, write word 0=32'h5555_5555 on the RESP-entry edge -> response is 32'hAAAA_AAAA; the next read returns 32'h5555_5555.
REQ-042 Reset test: assert rst in cycle k+1 after an accept in cycle k (LATENCY=3) -> no resp_valid ever appears for that request; req_ready=1 after reset deasserts; array contents are preserved.
REQ-043 Latency sweep: LATENCY=1 and LATENCY=15, streaming 100 sequential pcs -> each response arrives exactly LATENCY cycles after its accept, with in-order correct data.
